mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle RV32I control unit; successor to the single-cycle combinational decoder.
- Sequences each instruction through a fetch/decode/execute/memory/writeback FSM over one shared, handshaked memory port.
- Decodes the full RV32I integer subset.
- Traps on illegal encodings and on memory timeouts.
- Drives the existing datapath encodings (EXTOp, ALUOp, NPCOp, WDSel) unchanged, plus multi-cycle strobes.

Parameters:
TIMEOUT, 15, max cycles MemRead/MemWrite may wait for mem_ready; 0 disables the timeout.
TO_W, 4, width of the wait counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
Op  in  7  opcode from IR
Funct7  in  7  IR[31:25]
Funct3  in  3  IR[14:12]
Zero  in  1  ALU flag; 1 = branch condition true for the selected branch ALUOp
mem_ready  in  1  memory completes the current request this cycle
IRWrite  out  1  latch fetched word into IR
PCWrite  out  1  update PC with NPC
MemRead  out  1  memory read request (fetch or load)
MemWrite  out  1  memory write request
RegWrite  out  1  register file write
IorD  out  1  0 = address from PC, 1 = address from ALU
EXTOp  out  6  one-hot: SHAMT 100000, I 010000, S 001000, B 000100, U 000010, J 000001
ALUOp  out  5  existing codes: nop 0, lui 1, auipc 2, add 3, sub 4, bne 5, blt 6, bge 7, bltu 8, bgeu 9, slt 10, sltu 11, xor 12, or 13, and 14, sll 15, srl 16, sra 17
NPCOp  out  3  000 +4, 001 branch, 010 jal, 100 jalr
ALUSrc  out  1  ALU B from immediate
WDSel  out  2  00 ALU, 01 MEM, 10 PC+4
DMType  out  3  000 w, 001 h, 010 hu, 011 b, 100 bu
state  out  3  IF 0, ID 1, EX 2, MEM 3, WB 4, TRAP 5
instr_done  out  1  one-cycle pulse when an instruction retires
cause  out  2  00 none, 01 illegal instruction, 10 memory timeout; sticky

Behaviour:
- Reset: at the rst edge, state=IF, wait counter=0, cause=00.
  - While rst=1, all strobes (IRWrite, PCWrite, MemRead, MemWrite, RegWrite, instr_done) are forced to 0.
  - Other outputs are 0 out of reset. Reset in any state, including TRAP, aborts to IF.
- Outputs are combinational from the state register plus Op/Funct fields. IR is stable from ID onward.
- IF: MemRead=1, IorD=0.
  - Hold until mem_ready=1; in that cycle IRWrite=1, then go to ID.
- ID: decode only, no strobes.
  - Illegal opcode/funct combination: go to TRAP, cause=01.
  - Otherwise go to EX.
- EX: drive ALUOp, ALUSrc, EXTOp.
  - Branch: PCWrite=1; NPCOp=001 if Zero, else 000. Branch ALUOp mapping: beq uses sub; bne/blt/bge/bltu/bgeu use their own codes. instr_done=1, next state IF.
  - Load/store: ALUOp=add, ALUSrc=1, EXTOp I (load) or S (store); next state MEM.
  - All others: next state WB.
- MEM: IorD=1. Load asserts MemRead; store asserts MemWrite (DMType from Funct3). Request is held constant until mem_ready.
  - Store completion: PCWrite=1, NPCOp=000, instr_done=1, next state IF.
  - Load completion: next state WB.
- WB: RegWrite=1, PCWrite=1, instr_done=1, next state IF.
  - WDSel: 01 for load, 10 for jal/jalr, else 00.
  - NPCOp: 010 for jal, 100 for jalr, else 000.
- Rd=x0 is not special-cased; the register file ignores writes to x0.
- Decoded instructions:
  - R-type: add, sub, sll, slt, sltu, xor, srl, sra, or, and. Funct7 must be 0000000, except sub/sra which require 0100000.
  - I-type ALU: addi, slti, sltiu, xori, ori, andi use EXTOp I. slli/srli/srai use EXTOp SHAMT with Funct7 checks as for R-type.
  - Loads: lb, lh, lw, lbu, lhu.
  - Stores: sb, sh, sw.
  - Branches: beq, bne, blt, bge, bltu, bgeu.
  - Jumps: jal (EXTOp J); jalr (EXTOp I, Funct3 000, ALUOp add).
  - Upper immediates: lui (ALUOp lui, EXTOp U); auipc (ALUOp auipc, EXTOp U).
  - Anything else is illegal.
- Timeout: the counter clears on entry to IF/MEM and increments each cycle in IF/MEM while mem_ready=0.
  - When it reaches TIMEOUT (TIMEOUT>0) without mem_ready, go to TRAP, cause=10.
  - mem_ready in the same cycle the count reaches TIMEOUT counts as success.
- TRAP: all strobes 0. Remain there until rst.

Test Plan:
- Reset mid-MEM of sw, with mem_ready low and rst=1 for one edge -> state=0, MemWrite=0 during rst, cause=00, next fetch begins.
- add x3,x1,x2 (0x002081B3), mem_ready=1 always -> states 0,1,2,4; RegWrite=1 and ALUOp=3 in WB; instr_done after 4 cycles.
- lw (0x0000A183), mem_ready delayed 3 cycles in MEM -> MemRead held 4 cycles with IorD=1; WB WDSel=01, DMType=000; 5+3 cycles total.
- bne (Funct3 001, op 1100011) with Zero=1, then Zero=0 -> ALUOp=5; NPCOp=001 then 000; PCWrite=1 in EX; 3 cycles each.
- Opcode 0x7F, or R-type Funct7=0000001 -> TRAP after ID, cause=01, no strobes for 20 further cycles.
- TIMEOUT=15, mem_ready held low in IF -> TRAP on the 15th wait cycle, cause=10; repeat with mem_ready on cycle 15 -> IRWrite=1, no trap.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control unit: sequences IF/ID/EX/MEM/WB over one handshaked memory port,
// trapping on illegal encodings and on memory requests that wait too long for mem_ready.
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic [5:0] EXTOp,
    output logic [4:0] ALUOp,
    output logic [2:0] NPCOp,
    output logic       ALUSrc,
    output logic [1:0] WDSel,
    output logic [2:0] DMType,
    output logic [2:0] state,
    output logic       instr_done,
    output logic [1:0] cause
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [5:0] ExtNone  = 6'b000000;
    localparam logic [5:0] ExtShamt = 6'b100000;
    localparam logic [5:0] ExtI     = 6'b010000;
    localparam logic [5:0] ExtS     = 6'b001000;
    localparam logic [5:0] ExtB     = 6'b000100;
    localparam logic [5:0] ExtU     = 6'b000010;
    localparam logic [5:0] ExtJ     = 6'b000001;

    localparam logic [4:0] AluNop   = 5'd0;
    localparam logic [4:0] AluLui   = 5'd1;
    localparam logic [4:0] AluAuipc = 5'd2;
    localparam logic [4:0] AluAdd   = 5'd3;
    localparam logic [4:0] AluSub   = 5'd4;
    localparam logic [4:0] AluBne   = 5'd5;
    localparam logic [4:0] AluBlt   = 5'd6;
    localparam logic [4:0] AluBge   = 5'd7;
    localparam logic [4:0] AluBltu  = 5'd8;
    localparam logic [4:0] AluBgeu  = 5'd9;
    localparam logic [4:0] AluSlt   = 5'd10;
    localparam logic [4:0] AluSltu  = 5'd11;
    localparam logic [4:0] AluXor   = 5'd12;
    localparam logic [4:0] AluOr    = 5'd13;
    localparam logic [4:0] AluAnd   = 5'd14;
    localparam logic [4:0] AluSll   = 5'd15;
    localparam logic [4:0] AluSrl   = 5'd16;
    localparam logic [4:0] AluSra   = 5'd17;

    localparam logic [2:0] DmW  = 3'b000;
    localparam logic [2:0] DmH  = 3'b001;
    localparam logic [2:0] DmHu = 3'b010;
    localparam logic [2:0] DmB  = 3'b011;
    localparam logic [2:0] DmBu = 3'b100;

    localparam logic [2:0] NpcSeq    = 3'b000;
    localparam logic [2:0] NpcBranch = 3'b001;
    localparam logic [2:0] NpcJal    = 3'b010;
    localparam logic [2:0] NpcJalr   = 3'b100;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    localparam int unsigned ToLastInt = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] ToLast = TO_W'(ToLastInt);

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StTrap = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        KAlu,
        KLoad,
        KStore,
        KBranch,
        KJal,
        KJalr
    } kind_e;

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;

    logic            dec_legal;
    kind_e           dec_kind;
    logic [4:0]      dec_alu;
    logic [5:0]      dec_ext;
    logic            dec_src;
    logic [2:0]      dec_dm;
    logic            timeout_hit;

    function automatic logic [4:0] alu_of_f3(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    always_comb begin
        dec_legal = 1'b0;
        dec_kind  = KAlu;
        dec_alu   = AluNop;
        dec_ext   = ExtNone;
        dec_src   = 1'b0;
        dec_dm    = DmW;
        case (Op)
            OpR: begin
                dec_alu = alu_of_f3(Funct3);
                if (Funct3 == 3'b000 || Funct3 == 3'b101) begin
                    dec_legal = (Funct7 == F7Zero) || (Funct7 == F7Alt);
                    if (Funct7 == F7Alt) dec_alu = (Funct3 == 3'b000) ? AluSub : AluSra;
                end else begin
                    dec_legal = (Funct7 == F7Zero);
                end
            end
            OpImm: begin
                dec_alu = alu_of_f3(Funct3);
                dec_src = 1'b1;
                dec_ext = ExtI;
                if (Funct3 == 3'b001) begin
                    dec_ext   = ExtShamt;
                    dec_legal = (Funct7 == F7Zero);
                end else if (Funct3 == 3'b101) begin
                    dec_ext   = ExtShamt;
                    dec_legal = (Funct7 == F7Zero) || (Funct7 == F7Alt);
                    if (Funct7 == F7Alt) dec_alu = AluSra;
                end else begin
                    dec_legal = 1'b1;
                end
            end
            OpLoad: begin
                dec_kind  = KLoad;
                dec_alu   = AluAdd;
                dec_src   = 1'b1;
                dec_ext   = ExtI;
                dec_legal = 1'b1;
                case (Funct3)
                    3'b000:  dec_dm = DmB;
                    3'b001:  dec_dm = DmH;
                    3'b010:  dec_dm = DmW;
                    3'b100:  dec_dm = DmBu;
                    3'b101:  dec_dm = DmHu;
                    default: dec_legal = 1'b0;
                endcase
            end
            OpStore: begin
                dec_kind  = KStore;
                dec_alu   = AluAdd;
                dec_src   = 1'b1;
                dec_ext   = ExtS;
                dec_legal = 1'b1;
                case (Funct3)
                    3'b000:  dec_dm = DmB;
                    3'b001:  dec_dm = DmH;
                    3'b010:  dec_dm = DmW;
                    default: dec_legal = 1'b0;
                endcase
            end
            OpBranch: begin
                dec_kind  = KBranch;
                dec_ext   = ExtB;
                dec_legal = 1'b1;
                case (Funct3)
                    3'b000:  dec_alu = AluSub;
                    3'b001:  dec_alu = AluBne;
                    3'b100:  dec_alu = AluBlt;
                    3'b101:  dec_alu = AluBge;
                    3'b110:  dec_alu = AluBltu;
                    3'b111:  dec_alu = AluBgeu;
                    default: dec_legal = 1'b0;
                endcase
            end
            OpJal: begin
                dec_kind  = KJal;
                dec_ext   = ExtJ;
                dec_legal = 1'b1;
            end
            OpJalr: begin
                dec_kind  = KJalr;
                dec_alu   = AluAdd;
                dec_src   = 1'b1;
                dec_ext   = ExtI;
                dec_legal = (Funct3 == 3'b000);
            end
            OpLui: begin
                dec_alu   = AluLui;
                dec_src   = 1'b1;
                dec_ext   = ExtU;
                dec_legal = 1'b1;
            end
            OpAuipc: begin
                dec_alu   = AluAuipc;
                dec_src   = 1'b1;
                dec_ext   = ExtU;
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // A cycle that brings the wait count up to TIMEOUT with mem_ready still low is fatal.
    assign timeout_hit = (TIMEOUT != 0) && !mem_ready && (cnt_q == ToLast);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IorD       = 1'b0;
        EXTOp      = ExtNone;
        ALUOp      = AluNop;
        NPCOp      = NpcSeq;
        ALUSrc     = 1'b0;
        WDSel      = 2'b00;
        DMType     = DmW;
        instr_done = 1'b0;

        if (state_q == StEx || state_q == StMem || state_q == StWb) begin
            EXTOp  = dec_ext;
            ALUOp  = dec_alu;
            ALUSrc = dec_src;
        end

        case (state_q)
            StIf: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    state_d = StId;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end
            end
            StId: begin
                if (!dec_legal) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                case (dec_kind)
                    KBranch: begin
                        PCWrite    = 1'b1;
                        NPCOp      = Zero ? NpcBranch : NpcSeq;
                        instr_done = 1'b1;
                        state_d    = StIf;
                    end
                    KLoad, KStore: state_d = StMem;
                    default:       state_d = StWb;
                endcase
            end
            StMem: begin
                IorD     = 1'b1;
                DMType   = dec_dm;
                MemRead  = (dec_kind == KLoad);
                MemWrite = (dec_kind == KStore);
                if (mem_ready) begin
                    if (dec_kind == KStore) begin
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = StIf;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout_hit) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end
            end
            StWb: begin
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = StIf;
                if (dec_kind == KLoad) begin
                    WDSel  = 2'b01;
                    DMType = dec_dm;
                end else if (dec_kind == KJal || dec_kind == KJalr) begin
                    WDSel = 2'b10;
                end
                if (dec_kind == KJal) NPCOp = NpcJal;
                else if (dec_kind == KJalr) NPCOp = NpcJalr;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StIf;
        endcase

        if (rst) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    // The wait count only survives while parked in IF or MEM; any transition restarts it.
    always_comb begin
        cnt_d = '0;
        if ((state_q == StIf || state_q == StMem) && state_d == state_q) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIf;
            cnt_q   <= '0;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign state = state_q;
    assign cause = cause_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: mnemonic-level reference model checked every cycle, plus directed
// sequences with hand-computed literal expectations.
module tb_mc_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        Zero;
    logic        mem_ready;
    logic        IRWrite, PCWrite, MemRead, MemWrite, RegWrite, IorD, ALUSrc, instr_done;
    logic [5:0]  EXTOp;
    logic [4:0]  ALUOp;
    logic [2:0]  NPCOp, DMType, state;
    logic [1:0]  WDSel, cause;

    int checks = 0;
    int errors = 0;

    mc_ctrl #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (ir[6:0]),
        .Funct7    (ir[31:25]),
        .Funct3    (ir[14:12]),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IorD      (IorD),
        .EXTOp     (EXTOp),
        .ALUOp     (ALUOp),
        .NPCOp     (NPCOp),
        .ALUSrc    (ALUSrc),
        .WDSel     (WDSel),
        .DMType    (DMType),
        .state     (state),
        .instr_done(instr_done),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction -> mnemonic -> attribute tables.
    localparam int KAlu = 0, KLd = 1, KSt = 2, KBr = 3, KJal = 4, KJalr = 5;
    int    k_tab[string];
    int    alu_tab[string];
    int    ext_tab[string];
    int    src_tab[string];
    int    dm_tab[string];
    string r_nm[8]  = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
    string i_nm[8]  = '{"addi", "slli", "slti", "sltiu", "xori", "srli", "ori", "andi"};
    string ld_nm[8] = '{"lb", "lh", "lw", "ill", "lbu", "lhu", "ill", "ill"};
    string st_nm[8] = '{"sb", "sh", "sw", "ill", "ill", "ill", "ill", "ill"};
    string br_nm[8] = '{"beq", "bne", "ill", "ill", "blt", "bge", "bltu", "bgeu"};

    task automatic def(input string m, input int k, input int alu, input int ext, input int src,
                       input int dm);
        k_tab[m] = k; alu_tab[m] = alu; ext_tab[m] = ext; src_tab[m] = src; dm_tab[m] = dm;
    endtask

    function automatic string mnem(input logic [31:0] w);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0100000 && f3 == 3'd0) return "sub";
                if (f7 == 7'b0100000 && f3 == 3'd5) return "sra";
                if (f7 != 7'd0) return "ill";
                return r_nm[f3];
            end
            7'b0010011: begin
                if (f3 == 3'd5 && f7 == 7'b0100000) return "srai";
                if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'd0) return "ill";
                return i_nm[f3];
            end
            7'b0000011: return ld_nm[f3];
            7'b0100011: return st_nm[f3];
            7'b1100011: return br_nm[f3];
            7'b1101111: return "jal";
            7'b1100111: begin
                if (f3 == 3'd0) return "jalr";
                return "ill";
            end
            7'b0110111: return "lui";
            7'b0010111: return "auipc";
            default:    return "ill";
        endcase
    endfunction

    int m_st, m_wait, m_cause;

    initial begin
        def("add", KAlu, 3, 0, 0, 0);   def("sub", KAlu, 4, 0, 0, 0);
        def("sll", KAlu, 15, 0, 0, 0);  def("slt", KAlu, 10, 0, 0, 0);
        def("sltu", KAlu, 11, 0, 0, 0); def("xor", KAlu, 12, 0, 0, 0);
        def("srl", KAlu, 16, 0, 0, 0);  def("sra", KAlu, 17, 0, 0, 0);
        def("or", KAlu, 13, 0, 0, 0);   def("and", KAlu, 14, 0, 0, 0);
        def("addi", KAlu, 3, 16, 1, 0); def("slti", KAlu, 10, 16, 1, 0);
        def("sltiu", KAlu, 11, 16, 1, 0); def("xori", KAlu, 12, 16, 1, 0);
        def("ori", KAlu, 13, 16, 1, 0); def("andi", KAlu, 14, 16, 1, 0);
        def("slli", KAlu, 15, 32, 1, 0); def("srli", KAlu, 16, 32, 1, 0);
        def("srai", KAlu, 17, 32, 1, 0);
        def("lb", KLd, 3, 16, 1, 3);    def("lh", KLd, 3, 16, 1, 1);
        def("lw", KLd, 3, 16, 1, 0);    def("lbu", KLd, 3, 16, 1, 4);
        def("lhu", KLd, 3, 16, 1, 2);
        def("sb", KSt, 3, 8, 1, 3);     def("sh", KSt, 3, 8, 1, 1);
        def("sw", KSt, 3, 8, 1, 0);
        def("beq", KBr, 4, 4, 0, 0);    def("bne", KBr, 5, 4, 0, 0);
        def("blt", KBr, 6, 4, 0, 0);    def("bge", KBr, 7, 4, 0, 0);
        def("bltu", KBr, 8, 4, 0, 0);   def("bgeu", KBr, 9, 4, 0, 0);
        def("jal", KJal, 0, 1, 0, 0);   def("jalr", KJalr, 3, 16, 1, 0);
        def("lui", KAlu, 1, 2, 1, 0);   def("auipc", KAlu, 2, 2, 1, 0);

        @(posedge clk);
        m_st = 0; m_wait = 0; m_cause = 0;
        forever begin
            string m;
            int k, n_st, n_wait, n_cause;
            int e_irw, e_pcw, e_mr, e_mw, e_rw, e_iord, e_ext, e_alu, e_npc, e_src, e_wd;
            int e_dm, e_done;
            @(negedge clk);
            m = mnem(ir);
            k = (m != "ill") ? k_tab[m] : KAlu;
            {e_irw, e_pcw, e_mr, e_mw, e_rw, e_iord, e_done} = '0;
            {e_ext, e_alu, e_npc, e_src, e_wd, e_dm} = '0;
            n_st = m_st; n_wait = 0; n_cause = m_cause;
            if (m != "ill" && m_st >= 2 && m_st <= 4) begin
                e_alu = alu_tab[m]; e_ext = ext_tab[m]; e_src = src_tab[m];
            end
            case (m_st)
                0: begin
                    e_mr = 1;
                    if (mem_ready) begin e_irw = 1; n_st = 1; end
                    else if (m_wait + 1 == TIMEOUT) begin n_st = 5; n_cause = 2; end
                    else n_wait = m_wait + 1;
                end
                1: begin
                    if (m == "ill") begin n_st = 5; n_cause = 1; end
                    else n_st = 2;
                end
                2: begin
                    if (k == KBr) begin
                        e_pcw = 1; e_done = 1; e_npc = Zero ? 1 : 0; n_st = 0;
                    end else n_st = (k == KLd || k == KSt) ? 3 : 4;
                end
                3: begin
                    e_iord = 1; e_dm = dm_tab[m];
                    e_mr = (k == KLd); e_mw = (k == KSt);
                    if (mem_ready) begin
                        if (k == KSt) begin e_pcw = 1; e_done = 1; n_st = 0; end
                        else n_st = 4;
                    end else if (m_wait + 1 == TIMEOUT) begin n_st = 5; n_cause = 2; end
                    else n_wait = m_wait + 1;
                end
                4: begin
                    e_rw = 1; e_pcw = 1; e_done = 1; n_st = 0;
                    e_wd = (k == KLd) ? 1 : (k == KJal || k == KJalr) ? 2 : 0;
                    e_npc = (k == KJal) ? 2 : (k == KJalr) ? 4 : 0;
                    if (k == KLd) e_dm = dm_tab[m];
                end
                default: n_st = 5;
            endcase
            if (rst) begin
                {e_irw, e_pcw, e_mr, e_mw, e_rw, e_done} = '0;
                n_st = 0; n_wait = 0; n_cause = 0;
            end
            chk("state", int'(state), m_st);       chk("cause", int'(cause), m_cause);
            chk("IRWrite", int'(IRWrite), e_irw);  chk("PCWrite", int'(PCWrite), e_pcw);
            chk("MemRead", int'(MemRead), e_mr);   chk("MemWrite", int'(MemWrite), e_mw);
            chk("RegWrite", int'(RegWrite), e_rw); chk("IorD", int'(IorD), e_iord);
            chk("EXTOp", int'(EXTOp), e_ext);      chk("ALUOp", int'(ALUOp), e_alu);
            chk("NPCOp", int'(NPCOp), e_npc);      chk("ALUSrc", int'(ALUSrc), e_src);
            chk("WDSel", int'(WDSel), e_wd);       chk("DMType", int'(DMType), e_dm);
            chk("instr_done", int'(instr_done), e_done);
            @(posedge clk);
            m_st = n_st; m_wait = n_wait; m_cause = n_cause;
        end
    end

    // Snapshot of DUT outputs taken at the falling edge of each driven cycle.
    int s_st, s_done, s_irw, s_mr, s_mw, s_rw, s_pcw, s_iord, s_alu, s_npc, s_wd, s_dm, s_cause;

    task automatic cyc(input logic mr, input logic z);
        mem_ready = mr;
        Zero      = z;
        @(negedge clk);
        s_st = int'(state); s_done = int'(instr_done); s_irw = int'(IRWrite);
        s_mr = int'(MemRead); s_mw = int'(MemWrite); s_rw = int'(RegWrite);
        s_pcw = int'(PCWrite); s_iord = int'(IorD); s_alu = int'(ALUOp);
        s_npc = int'(NPCOp); s_wd = int'(WDSel); s_dm = int'(DMType); s_cause = int'(cause);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Runs one instruction with mem_ready always high; fails if it never retires.
    task automatic run_instr(input logic [31:0] w, input logic z);
        int n;
        ir = w;
        n  = 0;
        s_done = 0;
        while (s_done == 0 && n < 8) begin
            cyc(1'b1, z);
            n++;
        end
        chk("retire_bound", s_done, 1);
    endtask

    initial begin
        int seq[4];
        int cnt;
        rst = 1'b1; ir = 32'h0; Zero = 1'b0; mem_ready = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("reset_state", s_st, 0);
        chk("reset_cause", s_cause, 0);
        rst = 1'b0;

        // sw held in MEM, then reset lands mid-request
        ir = 32'h0020A023;
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("sw_mem_state", s_st, 3);
        chk("sw_memwrite", s_mw, 1);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        chk("rst_memwrite_low", s_mw, 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        chk("post_rst_state", s_st, 0);
        chk("post_rst_memread", s_mr, 1);
        run_instr(32'h0020A023, 1'b0);

        // add x3,x1,x2
        ir = 32'h002081B3;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0);
            seq[i] = s_st;
            if (i < 3) chk("add_early_done", s_done, 0);
        end
        chk("add_s0", seq[0], 0); chk("add_s1", seq[1], 1);
        chk("add_s2", seq[2], 2); chk("add_s3", seq[3], 4);
        chk("add_wb_regwrite", s_rw, 1);
        chk("add_wb_aluop", s_alu, 3);
        chk("add_done", s_done, 1);

        // lw with three-cycle memory stall
        ir = 32'h0000A183;
        cnt = 0;
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc((i == 3), 1'b0);
            if (s_mr == 1 && s_iord == 1 && s_st == 3) cnt++;
        end
        chk("lw_memread_cycles", cnt, 4);
        cyc(1'b1, 1'b0);
        chk("lw_wb_state", s_st, 4);
        chk("lw_wdsel", s_wd, 1);
        chk("lw_dmtype", s_dm, 0);
        chk("lw_done", s_done, 1);

        // bne taken then not taken
        ir = 32'h00209063;
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
        chk("bne_t_aluop", s_alu, 5); chk("bne_t_npc", s_npc, 1);
        chk("bne_t_pcwrite", s_pcw, 1); chk("bne_t_done", s_done, 1);
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        chk("bne_nt_npc", s_npc, 0); chk("bne_nt_done", s_done, 1);

        // broader decode coverage, checked by the model
        run_instr(32'h402081B3, 1'b0);  // sub
        run_instr(32'h4030D193, 1'b0);  // srai
        run_instr(32'h00309193, 1'b0);  // slli
        run_instr(32'h00208023, 1'b0);  // sb
        run_instr(32'h0000C183, 1'b0);  // lbu
        run_instr(32'h0000D183, 1'b0);  // lhu
        run_instr(32'h000000EF, 1'b0);  // jal
        chk("jal_wdsel", s_wd, 2); chk("jal_npc", s_npc, 2);
        run_instr(32'h000100E7, 1'b0);  // jalr
        chk("jalr_npc", s_npc, 4);
        run_instr(32'h000011B7, 1'b0);  // lui
        run_instr(32'h00001197, 1'b0);  // auipc
        run_instr(32'h00208063, 1'b1);  // beq
        run_instr(32'h0020F063, 1'b0);  // bgeu

        // illegal opcode: trap and stay silent
        ir = 32'h0000007F;
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1);
            if (s_irw | s_pcw | s_mr | s_mw | s_rw | s_done) cnt++;
        end
        chk("ill_op_state", s_st, 5); chk("ill_op_cause", s_cause, 1);
        chk("ill_op_strobes", cnt, 0);

        // reset out of TRAP, then R-type with Funct7=0000001
        do_reset();
        ir = 32'h022081B3;
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        chk("ill_f7_state", s_st, 5); chk("ill_f7_cause", s_cause, 1);
        do_reset();
        ir = 32'h40209193;  // slli with Funct7=0100000
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        chk("ill_slli_cause", s_cause, 1);
        do_reset();
        ir = 32'h0000B183;  // load funct3 011
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        chk("ill_ld_cause", s_cause, 1);

        // fetch timeout
        do_reset();
        ir = 32'h002081B3;
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0);
        chk("to_last_wait_state", s_st, 0);
        cyc(1'b1, 1'b0);
        chk("to_trap_state", s_st, 5); chk("to_trap_cause", s_cause, 2);

        // ready on the 15th wait cycle is success
        do_reset();
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("to_edge_irwrite", s_irw, 1);
        cyc(1'b1, 1'b0);
        chk("to_edge_state", s_st, 1);
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        chk("to_edge_done", s_done, 1);

        // load timeout in MEM
        ir = 32'h0000A183;
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("mem_to_state", s_st, 5); chk("mem_to_cause", s_cause, 2);
        do_reset();
        cyc(1'b0, 1'b0);
        chk("final_cause", s_cause, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
